sync_fifo: RTL and testbench

//  Single-clock circular FIFO, DEPTH entries of WIDTH bits, with full/empty flags and

---
 rtl/sync_fifo.sv | 104 ++++++++++
 tb/tb_sync_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with full/empty flags and overflow/underflow error pulses.
// Optional feature macro: GRAY_PTR_EN adds registered Gray-coded pointer outputs.
module sync_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 wr_error_o,
`ifdef GRAY_PTR_EN
  output logic                 rd_error_o,
  output logic [PTR_WIDTH:0]   wr_ptr_gray_o,
  output logic [PTR_WIDTH:0]   rd_ptr_gray_o
`else
  output logic                 rd_error_o
`endif
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

  // Pointers carry the wrap toggle in their MSB so full and empty can be told apart.
  logic [PTR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [PTR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               wrError_q, wrError_d;
  logic               rdError_q, rdError_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               doWrite, doRead;
  logic               ptrLowEqual;

  assign ptrLowEqual = (wrPtr_q[PTR_WIDTH-1:0] == rdPtr_q[PTR_WIDTH-1:0]);
  assign empty_o     = ptrLowEqual && (wrPtr_q[PTR_WIDTH] == rdPtr_q[PTR_WIDTH]);
  assign full_o      = ptrLowEqual && (wrPtr_q[PTR_WIDTH] != rdPtr_q[PTR_WIDTH]);

  assign doWrite = wr_en_i && !full_o;
  assign doRead  = rd_en_i && !empty_o;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    rdata_d   = rdata_q;
    wrError_d = wr_en_i && full_o;
    rdError_d = rd_en_i && empty_o;
    if (doWrite) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (doRead) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
      rdata_d = mem_q[rdPtr_q[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      rdata_q   <= '0;
      wrError_q <= 1'b0;
      rdError_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      rdata_q   <= rdata_d;
      wrError_q <= wrError_d;
      rdError_q <= rdError_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (doWrite) begin
      mem_q[wrPtr_q[PTR_WIDTH-1:0]] <= wdata_i;
    end
  end

  assign rdata_o    = rdata_q;
  assign wr_error_o = wrError_q;
  assign rd_error_o = rdError_q;

`ifdef GRAY_PTR_EN
  logic [PTR_WIDTH:0] wrGray_q, rdGray_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      wrGray_q <= '0;
      rdGray_q <= '0;
    end else begin
      wrGray_q <= wrPtr_d ^ (wrPtr_d >> 1);
      rdGray_q <= rdPtr_d ^ (rdPtr_d >> 1);
    end
  end

  assign wr_ptr_gray_o = wrGray_q;
  assign rd_ptr_gray_o = rdGray_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH=16, WIDTH=8).
// Exercises fill, drain, overflow, underflow, simultaneous access, wrap and mid-run clear.
module tb_sync_fifo;

  logic       clk;
  logic       clr;
  logic       wrEn;
  logic       rdEn;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic       wrErr;
  logic       rdErr;
  int         vectorCount = 0;
  int         missCount   = 0;
`ifdef GRAY_PTR_EN
  logic [4:0] wrGray, rdGray, prevWrGray, prevRdGray;
`endif

  sync_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .wr_en_i    (wrEn),
    .wdata_i    (wdata),
    .rd_en_i    (rdEn),
    .rdata_o    (rdata),
    .full_o     (full),
    .empty_o    (empty),
    .wr_error_o (wrErr),
`ifdef GRAY_PTR_EN
    .rd_error_o    (rdErr),
    .wr_ptr_gray_o (wrGray),
    .rd_ptr_gray_o (rdGray)
`else
    .rd_error_o (rdErr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request, let it take effect on the next rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd);
    wrEn  = wr;
    wdata = d;
    rdEn  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    clr   = 1'b1;
    wrEn  = 1'b0;
    rdEn  = 1'b0;
    wdata = 8'h00;
    #12;
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_wrerr", wrErr, 0);
    checkOutput("rst_rderr", rdErr, 0);
`ifdef GRAY_PTR_EN
    checkOutput("rst_wrgray", wrGray, 0);
    checkOutput("rst_rdgray", rdGray, 0);
`endif
    clr = 1'b0;

    $display("[TB] fill 16 then drain 16");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i * 3), 1'b0);
      checkOutput($sformatf("fill%0d_full", i), full, (i == 15) ? 1 : 0);
      checkOutput($sformatf("fill%0d_empty", i), empty, 0);
      checkOutput($sformatf("fill%0d_wrerr", i), wrErr, 0);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d_data", i), rdata, 8'h11 + 8'(i * 3));
      checkOutput($sformatf("drain%0d_empty", i), empty, (i == 15) ? 1 : 0);
      checkOutput($sformatf("drain%0d_full", i), full, 0);
      checkOutput($sformatf("drain%0d_rderr", i), rdErr, 0);
    end

    $display("[TB] overflow: 19 writes from empty");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
      checkOutput($sformatf("ovf%0d_full", i), full, (i >= 15) ? 1 : 0);
      checkOutput($sformatf("ovf%0d_wrerr", i), wrErr, (i >= 16) ? 1 : 0);
    end
    // Full with simultaneous read+write: write rejected, read proceeds.
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("fullrw_data", rdata, 8'h40);
    checkOutput("fullrw_wrerr", wrErr, 1);
    checkOutput("fullrw_full", full, 0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("ovfrd%0d_data", i), rdata, 8'h40 + 8'(i));
      checkOutput($sformatf("ovfrd%0d_wrerr", i), wrErr, 0);
    end
    checkOutput("ovf_empty", empty, 1);

    $display("[TB] underflow: 16 writes then 19 reads");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0);
    end
    checkOutput("udf_full", full, 1);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("udf%0d_data", i), rdata, (i < 16) ? 8'h80 + 8'(i) : 8'h8F);
      checkOutput($sformatf("udf%0d_rderr", i), rdErr, (i >= 16) ? 1 : 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("udf_idle_rderr", rdErr, 0);
    checkOutput("udf_idle_data", rdata, 8'h8F);

    $display("[TB] fill to 8 then 20 simultaneous read+write");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0);
    end
`ifdef GRAY_PTR_EN
    prevWrGray = wrGray;
    prevRdGray = rdGray;
`endif
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'hC8 + 8'(k), 1'b1);
      checkOutput($sformatf("rw%0d_data", k), rdata, 8'hC0 + 8'(k));
      checkOutput($sformatf("rw%0d_empty", k), empty, 0);
      checkOutput($sformatf("rw%0d_full", k), full, 0);
`ifdef GRAY_PTR_EN
      checkOutput($sformatf("rw%0d_wrgray1", k), $countones(wrGray ^ prevWrGray), 1);
      checkOutput($sformatf("rw%0d_rdgray1", k), $countones(rdGray ^ prevRdGray), 1);
      prevWrGray = wrGray;
      prevRdGray = rdGray;
`endif
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("rwdrain%0d_data", i), rdata, 8'hD4 + 8'(i));
    end
    checkOutput("rwdrain_empty", empty, 1);

    // Empty with simultaneous read+write: read rejected, write proceeds.
    applyStimulus(1'b1, 8'h5A, 1'b1);
    checkOutput("emptyrw_rderr", rdErr, 1);
    checkOutput("emptyrw_data", rdata, 8'hDB);
    checkOutput("emptyrw_empty", empty, 0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("emptyrw_rd_data", rdata, 8'h5A);
    checkOutput("emptyrw_rd_rderr", rdErr, 0);
    checkOutput("emptyrw_rd_empty", empty, 1);

    $display("[TB] clear with 5 words stored");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
    end
    wrEn = 1'b0;
    checkOutput("preclr_empty", empty, 0);
    #2 clr = 1'b1;
    #1;
    checkOutput("clr_empty", empty, 1);
    checkOutput("clr_full", full, 0);
    checkOutput("clr_rdata", rdata, 8'h00);
    clr = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("postclr_rderr", rdErr, 1);
    checkOutput("postclr_rdata", rdata, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("postclr_idle_rderr", rdErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
